// File: rtl/mctrl_pkg.sv
// ============================================================================
// mctrl_pkg : state encodings, opcode/funct values and select codes
//             shared by the multi-cycle MIPS control unit.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package mctrl_pkg;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_R_EX    = 4'd6,
      S_R_WB    = 4'd7,
      S_BEQ     = 4'd8,
      S_JMP     = 4'd9,
      S_I_EX    = 4'd10,
      S_I_WB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_SLTI  = 6'h0A;

   localparam logic [5:0] FUN_ADD = 6'h20;
   localparam logic [5:0] FUN_SUB = 6'h22;
   localparam logic [5:0] FUN_AND = 6'h24;
   localparam logic [5:0] FUN_OR  = 6'h25;
   localparam logic [5:0] FUN_XOR = 6'h26;
   localparam logic [5:0] FUN_NOR = 6'h27;
   localparam logic [5:0] FUN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that wait on the memory handshake and feed the stall watchdog
   function automatic logic is_wait_state(input state_t s);
      return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

   function automatic logic [2:0] itype_alu(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_ctrl_if.sv
// ============================================================================
// mcycle_ctrl_if : control-unit <-> datapath/memory signal bundle.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

interface mcycle_ctrl_if;
   logic [5:0] OP;
   logic [5:0] Fun;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic [2:0] ALU_Control;
   logic [3:0] state;
   logic       inst_done;
   logic       illegal;
   logic       mem_timeout;

   modport slave (
      input  OP, Fun, zero, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
             ALU_Control, state, inst_done, illegal, mem_timeout
   );

   modport master (
      output OP, Fun, zero, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
             ALU_Control, state, inst_done, illegal, mem_timeout
   );
endinterface

`default_nettype wire

// File: rtl/mcycle_ctrl_alu_fun_decode.sv
// ============================================================================
// alu_fun_decode : R-type funct field -> ALU_Control with a validity flag.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_fun_decode
   import mctrl_pkg::*;
(
   input  logic [5:0] fun,
   output logic [2:0] alu_ctl,
   output logic       valid
);

   always_comb begin
      alu_ctl = ALU_ADD;
      valid   = 1'b1;
      case (fun)
         FUN_ADD: alu_ctl = ALU_ADD;
         FUN_SUB: alu_ctl = ALU_SUB;
         FUN_AND: alu_ctl = ALU_AND;
         FUN_OR:  alu_ctl = ALU_OR;
         FUN_XOR: alu_ctl = ALU_XOR;
         FUN_NOR: alu_ctl = ALU_NOR;
         FUN_SLT: alu_ctl = ALU_SLT;
         default: valid   = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mcycle_ctrl.sv
// ============================================================================
// mcycle_ctrl : multi-cycle MIPS control FSM with memory-stall watchdog.
//               Define MCTRL_ITYPE_EN to add addi/andi/ori/slti support.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
)(
   input  logic            clk,
   input  logic            rst,
   mcycle_ctrl_if.slave    bus
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] w_fun_alu;
   logic       w_fun_valid;
   logic       w_stall;
   logic       w_timeout;

   alu_fun_decode u_fun_dec (
      .fun     (bus.Fun),
      .alu_ctl (w_fun_alu),
      .valid   (w_fun_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IF;
      else      r_state <= w_next;
   end

   // A stall is exactly the condition under which the state holds
   assign w_stall = is_wait_state(r_state) && !bus.mem_ready;

   generate
      if (MEM_WAIT_MAX > 0) begin : g_wdog
         localparam int             CW    = $clog2(MEM_WAIT_MAX + 1);
         localparam logic [CW-1:0]  C_MAX = CW'(MEM_WAIT_MAX);
         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)               r_cnt <= '0;
            else if (!w_stall)      r_cnt <= '0;
            else if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
         end

         assign w_timeout = w_stall && (r_cnt == C_MAX - 1'b1);
      end else begin : g_no_wdog
         assign w_timeout = 1'b0;
      end
   endgenerate

   assign bus.mem_timeout = w_timeout & rst;
   assign bus.state       = r_state;

   always_comb begin
      w_next          = r_state;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = SRCB_RT;
      bus.PCSource    = PCSRC_ALU;
      bus.ALU_Control = ALU_AND;
      bus.inst_done   = 1'b0;
      bus.illegal     = 1'b0;
      case (r_state)
         S_IF: begin
            bus.MemRead     = 1'b1;
            bus.ALUSrcB     = SRCB_FOUR;
            bus.ALU_Control = ALU_ADD;
            // Fetch writes stay off while reset is held, even with memory ready
            bus.IRWrite     = bus.mem_ready & rst;
            bus.PCWrite     = bus.mem_ready & rst;
            if (bus.mem_ready) w_next = S_ID;
         end
         S_ID: begin
            bus.ALUSrcB     = SRCB_IMM_SH;
            bus.ALU_Control = ALU_ADD;
            case (bus.OP)
               OP_LW, OP_SW: w_next = S_MEM_ADR;
               OP_RTYPE:     w_next = S_R_EX;
               OP_BEQ:       w_next = S_BEQ;
               OP_J:         w_next = S_JMP;
`ifdef MCTRL_ITYPE_EN
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_I_EX;
`endif
               default: begin
                  bus.illegal = 1'b1;
                  w_next      = S_IF;
               end
            endcase
         end
         S_MEM_ADR: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = SRCB_IMM;
            bus.ALU_Control = ALU_ADD;
            w_next          = (bus.OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            if (bus.mem_ready) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            bus.RegWrite  = 1'b1;
            bus.MemtoReg  = 1'b1;
            bus.inst_done = 1'b1;
            w_next        = S_IF;
         end
         S_MEM_WR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            if (bus.mem_ready) begin
               bus.inst_done = 1'b1;
               w_next        = S_IF;
            end
         end
         S_R_EX: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = SRCB_RT;
            bus.ALU_Control = w_fun_alu;
            if (w_fun_valid) begin
               w_next = S_R_WB;
            end else begin
               bus.illegal = 1'b1;
               w_next      = S_IF;
            end
         end
         S_R_WB: begin
            bus.RegWrite  = 1'b1;
            bus.RegDst    = 1'b1;
            bus.inst_done = 1'b1;
            w_next        = S_IF;
         end
         S_BEQ: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = SRCB_RT;
            bus.ALU_Control = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = PCSRC_ALUOUT;
            bus.inst_done   = 1'b1;
            w_next          = S_IF;
         end
         S_JMP: begin
            bus.PCWrite   = 1'b1;
            bus.PCSource  = PCSRC_JUMP;
            bus.inst_done = 1'b1;
            w_next        = S_IF;
         end
`ifdef MCTRL_ITYPE_EN
         S_I_EX: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = SRCB_IMM;
            bus.ALU_Control = itype_alu(bus.OP);
            w_next          = S_I_WB;
         end
         S_I_WB: begin
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            w_next        = S_IF;
         end
`endif
         default: w_next = S_IF;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================================
// tb_mcycle_ctrl : directed-vector scoreboard bench for mcycle_ctrl.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mcycle_ctrl;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] alu;
        logic [3:0] st;
        logic       done, ill, tmo;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mcycle_ctrl_if bus ();

    mcycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ctl_t  exp_q[$];
    ctl_t  msk_q[$];
    string nm_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_tmo  = 0;
    int    wd_idx = 0;
    int    tmo_at = -1;

    function automatic ctl_t e_if(input logic rdy);
        ctl_t e = '0; e.mrd = 1; e.srcb = 2'b01; e.alu = 3'b010;
        e.irw = rdy; e.pcw = rdy; e.st = 4'd0; return e;
    endfunction
    function automatic ctl_t e_id(input logic ill);
        ctl_t e = '0; e.srcb = 2'b11; e.alu = 3'b010; e.ill = ill; e.st = 4'd1; return e;
    endfunction
    function automatic ctl_t e_madr();
        ctl_t e = '0; e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010; e.st = 4'd2; return e;
    endfunction
    function automatic ctl_t e_mrd();
        ctl_t e = '0; e.mrd = 1; e.iord = 1; e.st = 4'd3; return e;
    endfunction
    function automatic ctl_t e_mwb();
        ctl_t e = '0; e.rw = 1; e.m2r = 1; e.done = 1; e.st = 4'd4; return e;
    endfunction
    function automatic ctl_t e_mwr(input logic rdy);
        ctl_t e = '0; e.mwr = 1; e.iord = 1; e.done = rdy; e.st = 4'd5; return e;
    endfunction
    function automatic ctl_t e_rex(input logic [2:0] alu, input logic ill);
        ctl_t e = '0; e.srca = 1; e.alu = alu; e.ill = ill; e.st = 4'd6; return e;
    endfunction
    function automatic ctl_t e_rwb();
        ctl_t e = '0; e.rw = 1; e.rdst = 1; e.done = 1; e.st = 4'd7; return e;
    endfunction
    function automatic ctl_t e_beq();
        ctl_t e = '0; e.srca = 1; e.alu = 3'b110; e.pcwc = 1; e.pcsrc = 2'b01;
        e.done = 1; e.st = 4'd8; return e;
    endfunction
    function automatic ctl_t e_jmp();
        ctl_t e = '0; e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; e.st = 4'd9; return e;
    endfunction
    function automatic ctl_t e_iex(input logic [2:0] alu);
        ctl_t e = '0; e.srca = 1; e.srcb = 2'b10; e.alu = alu; e.st = 4'd10; return e;
    endfunction
    function automatic ctl_t e_iwb();
        ctl_t e = '0; e.rw = 1; e.done = 1; e.st = 4'd11; return e;
    endfunction

    task automatic chk(input logic cond, input string nm);
        n_chk++;
        if (cond) n_pass++;
        else $display("FAIL %s (state %0d, tmo pulses %0d at %0d)", nm, bus.state, n_tmo, tmo_at);
    endtask

    task automatic stepm(input ctl_t e, input ctl_t m, input string nm);
        exp_q.push_back(e);
        msk_q.push_back(m);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input ctl_t e, input string nm);
        stepm(e, '1, nm);
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fun, input string nm);
        bus.OP = op; bus.Fun = fun; bus.mem_ready = 1'b1;
        step(e_if(1'b1), {nm, "_if"});
        step(e_id(1'b0), {nm, "_id"});
    endtask

    always @(negedge clk) begin
        if (bus.mem_timeout === 1'b1) begin
            n_tmo++;
            tmo_at = wd_idx;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t        a;
            logic [23:0] ev, mv, av;
            string       nm;
            ev = exp_q.pop_front();
            mv = msk_q.pop_front();
            nm = nm_q.pop_front();
            a.pcw  = bus.PCWrite;  a.pcwc = bus.PCWriteCond; a.iord = bus.IorD;
            a.mrd  = bus.MemRead;  a.mwr  = bus.MemWrite;    a.irw  = bus.IRWrite;
            a.m2r  = bus.MemtoReg; a.rdst = bus.RegDst;      a.rw   = bus.RegWrite;
            a.srca = bus.ALUSrcA;  a.srcb = bus.ALUSrcB;     a.pcsrc = bus.PCSource;
            a.alu  = bus.ALU_Control; a.st = bus.state;      a.done = bus.inst_done;
            a.ill  = bus.illegal;  a.tmo  = bus.mem_timeout;
            av = a;
            n_chk++;
            if (((av ^ ev) & mv) == 24'h0) n_pass++;
            else $display("FAIL %s: got %h expected %h (state got %0d)", nm, av, ev, a.st);
        end
    end

    logic [5:0] fun_tab [7];
    logic [2:0] alu_tab [7];

    initial begin
        ctl_t e, m;
        fun_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111};
        bus.OP = 6'h00; bus.Fun = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;

        step(e_if(1'b0), "rst_if");
        step(e_if(1'b0), "rst_if2");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            fetch_decode(6'h00, fun_tab[i], "rtype");
            step(e_rex(alu_tab[i], 1'b0), "rtype_rex");
            step(e_rwb(), "rtype_rwb");
        end

        fetch_decode(6'h23, 6'h00, "lw");
        step(e_madr(), "lw_madr");
        bus.mem_ready = 1'b0;
        repeat (3) step(e_mrd(), "lw_rd_wait");
        bus.mem_ready = 1'b1;
        step(e_mrd(), "lw_rd_ok");
        step(e_mwb(), "lw_wb");

        fetch_decode(6'h2B, 6'h00, "sw");
        step(e_madr(), "sw_madr");
        bus.mem_ready = 1'b0;
        step(e_mwr(1'b0), "sw_wr_wait");
        bus.mem_ready = 1'b1;
        step(e_mwr(1'b1), "sw_wr_ok");

        bus.zero = 1'b1;
        fetch_decode(6'h04, 6'h00, "beq");
        step(e_beq(), "beq_ex");
        bus.zero = 1'b0;
        fetch_decode(6'h02, 6'h00, "j");
        step(e_jmp(), "j_ex");

        bus.OP = 6'h3F;
        step(e_if(1'b1), "badop_if");
        step(e_id(1'b1), "badop_id");
        step(e_if(1'b1), "badop_back_if");
        step(e_id(1'b1), "badop_id2");
        fetch_decode(6'h00, 6'h00, "badfun");
        m = '1; m.alu = 3'b000;
        stepm(e_rex(3'b000, 1'b1), m, "badfun_rex");

        fetch_decode(6'h23, 6'h00, "lwr");
        step(e_madr(), "lwr_madr");
        bus.mem_ready = 1'b0;
        step(e_mrd(), "lwr_rd_wait");
        rst = 1'b0;
        #1;
        chk(bus.state == 4'd0 && bus.MemRead == 1'b1 && bus.RegWrite == 1'b0 &&
            bus.IRWrite == 1'b0 && bus.PCWrite == 1'b0 && bus.MemWrite == 1'b0 &&
            bus.ALUSrcB == 2'b01 && bus.ALU_Control == 3'b010,
            "rst_state_immediate");
        step(e_if(1'b0), "rst_mid1");
        bus.mem_ready = 1'b1;
        #1;
        chk(bus.state == 4'd0 && bus.IRWrite == 1'b0 && bus.PCWrite == 1'b0 &&
            bus.RegWrite == 1'b0, "rst_state_held");
        step(e_if(1'b0), "rst_mid2");
        rst = 1'b1;
        #1;
        chk(bus.IRWrite == 1'b1 && bus.PCWrite == 1'b1, "rst_release_fetch");
        fetch_decode(6'h02, 6'h00, "rst_rel");
        step(e_jmp(), "rst_rel_j");

        bus.OP = 6'h0D; bus.mem_ready = 1'b0;
        n_tmo = 0;
        for (int i = 1; i <= 18; i++) begin
            wd_idx = i;
            e = e_if(1'b0);
            e.tmo = (i == 15);
            step(e, "wdog_if");
        end
        chk(n_tmo == 1 && tmo_at == 15 && bus.state == 4'd0, "wdog_expired_once");
        bus.mem_ready = 1'b1;
        step(e_if(1'b1), "wdog_if_ok");
`ifdef MCTRL_ITYPE_EN
        step(e_id(1'b0), "ori_id");
        step(e_iex(3'b001), "ori_iex");
        step(e_iwb(), "ori_iwb");
`else
        step(e_id(1'b1), "ori_illegal_id");
`endif
        step(e_if(1'b1), "final_if");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
